eth_tx_pkt_buffer: RTL

//   Two-bank (ping-pong) TX frame buffer that feeds eth_tx_fsm. User logic streams payload bytes
//   in with a valid/ready handshake. Each completed frame is handed to eth_tx_fsm via a start

---
 rtl/eth_tx_pkt_buffer_if.sv | 28 ++
 rtl/eth_tx_pkt_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkt_buffer_if.sv
// Payload write stream plus eth_tx_fsm handoff/read bundle for eth_tx_pkt_buffer.
// master = user logic / eth_tx_fsm side, slave = the buffer.
interface eth_tx_pkt_buffer_if;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_last;
   logic        wr_ready;
   logic        eth_tx_start;
   logic [15:0] eth_tx_size;
   logic        eth_busy;
   logic [15:0] eth_mem_rd_addr;
   logic [7:0]  eth_data_8b;
   logic        frame_drop;
   logic [31:0] tx_frame_cnt;
   logic [15:0] drop_cnt;

   modport master (
      output wr_valid, wr_data, wr_last, eth_busy, eth_mem_rd_addr,
      input  wr_ready, eth_tx_start, eth_tx_size, eth_data_8b, frame_drop,
             tx_frame_cnt, drop_cnt
   );

   modport slave (
      input  wr_valid, wr_data, wr_last, eth_busy, eth_mem_rd_addr,
      output wr_ready, eth_tx_start, eth_tx_size, eth_data_8b, frame_drop,
             tx_frame_cnt, drop_cnt
   );
endinterface

// File: rtl/eth_tx_pkt_buffer.sv
// Ping-pong TX payload buffer feeding eth_tx_fsm: one bank fills while the other is sent.
// Define ETH_TX_BUF_STATS_EN to build the tx_frame_cnt / drop_cnt statistics counters.
//
//  state       | meaning
//  S_IDLE      | waiting for bank[send_bank] FULL and eth_tx_fsm not busy
//  S_START     | holding eth_tx_start high for START_HOLD cycles
//  S_WAIT_BUSY | waiting for eth_tx_fsm to report busy
//  S_WAIT_DONE | frame in flight; release bank when busy falls
module eth_tx_pkt_buffer #(
   parameter int ADDR_W     = 11,
   parameter int MAX_LEN    = 1500,
   parameter int START_HOLD = 4
) (
   input logic                 i_eth_clk,
   input logic                 i_rst_n,
   eth_tx_pkt_buffer_if.slave  bus
);
   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_SENDING} bank_t;
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} sched_t;

   localparam int          DEPTH     = 2 ** (ADDR_W + 1);
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
   localparam logic [7:0]  HOLD_LAST = 8'(START_HOLD - 1);

   logic [7:0]  mem [DEPTH];
   bank_t       bank_st [2];
   logic [15:0] len [2];
   logic        wr_bank, send_bank, rdy_en, drop_flag;
   logic [15:0] wr_len;
   sched_t      state;
   logic [7:0]  cnt;
   logic        tx_start, frame_drop, rd_ok;
   logic [15:0] tx_size;
   logic [7:0]  rd_raw;
   logic        wr_ready, accept, wr_over, wr_en, rd_in_range, launch;

   // rdy_en keeps ready low while in reset even though both banks read EMPTY
   assign wr_ready    = rdy_en && (bank_st[wr_bank] == B_EMPTY || bank_st[wr_bank] == B_FILLING);
   assign accept      = bus.wr_valid && wr_ready;
   assign wr_over     = drop_flag || (wr_len >= MAX_LEN_W);
   assign wr_en       = accept && !wr_over;
   assign rd_in_range = (bus.eth_mem_rd_addr < len[send_bank]) &&
                        (bus.eth_mem_rd_addr[15:ADDR_W] == '0);
   assign launch      = (state == S_IDLE) && (bank_st[send_bank] == B_FULL) && !bus.eth_busy;

   always_ff @(posedge i_eth_clk) begin
      if (wr_en) mem[{wr_bank, wr_len[ADDR_W-1:0]}] <= bus.wr_data;
      rd_raw <= mem[{send_bank, bus.eth_mem_rd_addr[ADDR_W-1:0]}];
   end

   always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            bank_st[i] <= B_EMPTY;
            len[i]     <= '0;
         end
         wr_bank    <= 1'b0;
         send_bank  <= 1'b0;
         rdy_en     <= 1'b0;
         drop_flag  <= 1'b0;
         wr_len     <= '0;
         state      <= S_IDLE;
         cnt        <= '0;
         tx_start   <= 1'b0;
         tx_size    <= '0;
         frame_drop <= 1'b0;
         rd_ok      <= 1'b0;
      end else begin
         rdy_en     <= 1'b1;
         frame_drop <= 1'b0;
         rd_ok      <= rd_in_range;

         // writer only touches EMPTY/FILLING banks, scheduler only FULL/SENDING ones
         if (accept) begin
            if (bus.wr_last) begin
               wr_len    <= '0;
               drop_flag <= 1'b0;
               if (wr_over) begin
                  bank_st[wr_bank] <= B_EMPTY;
                  frame_drop       <= 1'b1;
               end else begin
                  bank_st[wr_bank] <= B_FULL;
                  len[wr_bank]     <= wr_len + 16'd1;
                  wr_bank          <= ~wr_bank;
               end
            end else begin
               wr_len           <= wr_len + 16'd1;
               bank_st[wr_bank] <= B_FILLING;
               if (wr_len >= MAX_LEN_W) drop_flag <= 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (launch) begin
                  bank_st[send_bank] <= B_SENDING;
                  tx_size            <= len[send_bank];
                  tx_start           <= 1'b1;
                  cnt                <= '0;
                  state              <= S_START;
               end
            end
            S_START: begin
               if (cnt == HOLD_LAST) begin
                  tx_start <= 1'b0;
                  state    <= S_WAIT_BUSY;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_WAIT_BUSY: begin
               if (bus.eth_busy) state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (!bus.eth_busy) begin
                  bank_st[send_bank] <= B_EMPTY;
                  send_bank          <= ~send_bank;
                  state              <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.wr_ready     = wr_ready;
   assign bus.eth_tx_start = tx_start;
   assign bus.eth_tx_size  = tx_size;
   assign bus.eth_data_8b  = rd_ok ? rd_raw : 8'h00;
   assign bus.frame_drop   = frame_drop;

`ifdef ETH_TX_BUF_STATS_EN
   logic [31:0] tx_frame_cnt;
   logic [15:0] drop_cnt;

   always_ff @(posedge i_eth_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_frame_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         if (launch)     tx_frame_cnt <= tx_frame_cnt + 32'd1;
         if (frame_drop) drop_cnt     <= drop_cnt + 16'd1;
      end
   end

   assign bus.tx_frame_cnt = tx_frame_cnt;
   assign bus.drop_cnt     = drop_cnt;
`else
   assign bus.tx_frame_cnt = '0;
   assign bus.drop_cnt     = '0;
`endif
endmodule
